// File: rtl/ans_delay_measure_fifo_pkg.sv
// ans_delay_pkg: shared types and width helpers for the answer-delay meter
package ans_delay_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, TIMEDOUT} state_t;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;
    typedef struct packed {
        logic                 timeout;
        logic [CNT_W_DEF-1:0] delay;
    } entry_t;
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/ans_delay_measure_fifo_if.sv
// ans_delay_measure_fifo_if: event strobes, config and result-FIFO read side
interface ans_delay_measure_fifo_if
    import ans_delay_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic                        p_send_finished_i;
    logic                        p_data_received_i;
    logic                        p_tick_i;
    logic                        p_rd_i;
    logic                        p_clr_i;
    logic [CNT_W-1:0]            timeout_limit_i;
    logic [CNT_W-1:0]            delay_o;
    logic                        timeout_flag_o;
    logic                        valid_o;
    logic [count_w(DEPTH)-1:0]   count_o;
    logic                        p_timeout_o;
    logic                        overflow_o;
    modport master (
        output p_send_finished_i, p_data_received_i, p_tick_i, p_rd_i, p_clr_i, timeout_limit_i,
        input  delay_o, timeout_flag_o, valid_o, count_o, p_timeout_o, overflow_o
    );
    modport slave (
        input  p_send_finished_i, p_data_received_i, p_tick_i, p_rd_i, p_clr_i, timeout_limit_i,
        output delay_o, timeout_flag_o, valid_o, count_o, p_timeout_o, overflow_o
    );
endinterface

// File: rtl/ans_delay_fifo.sv
// ans_delay_fifo: show-ahead circular buffer with occupancy count and overflow policy
module ans_delay_fifo #(
    parameter int W         = 17,
    parameter int DEPTH     = 4,
    parameter bit OVERWRITE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          empty, full, do_pop, lost, wr, adv;
    // Policy decode: a push into a full FIFO without a pop loses either the oldest or the new entry
    always_comb begin
        empty  = count == '0;
        full   = count == (AW+1)'(DEPTH);
        do_pop = pop && !empty;
        lost   = push && full && !do_pop;
        wr     = push && !(lost && !OVERWRITE);
        adv    = do_pop || (lost && OVERWRITE);
    end
    assign dout = empty ? '0 : mem[rp];
    // Pointers, count and sticky overflow; count kept separately so full and empty never alias
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wp       <= wp + AW'(wr);
            rp       <= rp + AW'(adv);
            count    <= count + (AW+1)'(wr) - (AW+1)'(adv);
            overflow <= overflow | lost;
        end
    end
    // Storage array needs no reset: unread slots are masked by the empty check
    always_ff @(posedge clk) begin
        if (wr && !clr) mem[wp] <= din;
    end
endmodule

// File: rtl/ans_delay_measure_fifo.sv
// ans_delay_measure_fifo: measures send-finished to data-received delay in ticks into a result FIFO
module ans_delay_measure_fifo
    import ans_delay_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MAX_DLY   = 999,
    parameter bit OVERWRITE = 1'b1
) (
    input logic clk,
    input logic rst,
    ans_delay_measure_fifo_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_DLY);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sf, dr, clr, timeout, push, p_timeout_q;
    assign sf  = bus.p_send_finished_i;
    assign dr  = bus.p_data_received_i;
    assign clr = bus.p_clr_i;
    // Next state and push decode; a received strobe beats a timeout in the same cycle
    always_comb begin
        timeout   = state == WAIT && |bus.timeout_limit_i && cnt >= bus.timeout_limit_i && !dr;
        push      = !clr && state == WAIT && (dr || timeout);
        state_nxt = clr ? IDLE :
                    sf  ? WAIT :
                    state == WAIT     ? (dr ? IDLE : timeout ? TIMEDOUT : WAIT) :
                    state == TIMEDOUT ? (dr ? IDLE : TIMEDOUT) : IDLE;
    end
    // State register and timeout pulse, aligned with the entry becoming visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p_timeout_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            p_timeout_q <= push && !dr;
        end
    end
    // Saturating tick counter, restarted by each send-finished strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr || sf) cnt <= '0;
        else if (state == WAIT && bus.p_tick_i && cnt != MAX) cnt <= cnt + 1'b1;
    end
    assign bus.p_timeout_o = p_timeout_q;
    ans_delay_fifo #(.W(CNT_W + 1), .DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .push     (push),
        .pop      (bus.p_rd_i),
        .din      ({!dr, cnt}),
        .dout     ({bus.timeout_flag_o, bus.delay_o}),
        .count    (bus.count_o),
        .overflow (bus.overflow_o)
    );
    assign bus.valid_o = |bus.count_o;
endmodule

// File: tb/tb_ans_delay_measure_fifo.sv
// tb_ans_delay_measure_fifo: scoreboard bench driving an overwrite and a drop-new instance in lockstep
module tb_ans_delay_measure_fifo;
    import ans_delay_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sf = 0, dr = 0, tk = 0, rd = 0, clr = 0;
    logic [15:0] limit = '0;
    int n_tests = 0, n_fail = 0;
    entry_t qa[$], qb[$];
    always #5 clk = ~clk;
    ans_delay_measure_fifo_if #(.CNT_W(16), .DEPTH(4)) a ();
    ans_delay_measure_fifo_if #(.CNT_W(16), .DEPTH(4)) b ();
    assign a.p_send_finished_i = sf;
    assign a.p_data_received_i = dr;
    assign a.p_tick_i          = tk;
    assign a.p_rd_i            = rd;
    assign a.p_clr_i           = clr;
    assign a.timeout_limit_i   = limit;
    assign b.p_send_finished_i = sf;
    assign b.p_data_received_i = dr;
    assign b.p_tick_i          = tk;
    assign b.p_rd_i            = rd;
    assign b.p_clr_i           = clr;
    assign b.timeout_limit_i   = limit;
    ans_delay_measure_fifo #(.CNT_W(16), .DEPTH(4), .MAX_DLY(999), .OVERWRITE(1'b1)) u_ow (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );
    ans_delay_measure_fifo #(.CNT_W(16), .DEPTH(4), .MAX_DLY(999), .OVERWRITE(1'b0)) u_keep (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input logic s, input logic d, input logic t, input logic r, input logic c);
        sf = s; dr = d; tk = t; rd = r; clr = c;
        @(posedge clk);
        #1;
        sf = 0; dr = 0; tk = 0; rd = 0; clr = 0;
    endtask
    task automatic exp_push(input entry_t e);
        if (qa.size() == 4) void'(qa.pop_front());
        qa.push_back(e);
        if (qb.size() < 4) qb.push_back(e);
    endtask
    task automatic measure(input int n);
        step(1, 0, 0, 0, 0);
        repeat (n) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        exp_push({1'b0, 16'(n > 999 ? 999 : n)});
    endtask
    task automatic pop_check(input string tag);
        entry_t ea, eb;
        ea = qa.size() != 0 ? qa[0] : '0;
        eb = qb.size() != 0 ? qb[0] : '0;
        check({tag, "/a_valid"}, a.valid_o, qa.size() != 0);
        check({tag, "/a_delay"}, a.delay_o, ea.delay);
        check({tag, "/a_flag"}, a.timeout_flag_o, ea.timeout);
        check({tag, "/b_delay"}, b.delay_o, eb.delay);
        check({tag, "/b_flag"}, b.timeout_flag_o, eb.timeout);
        step(0, 0, 0, 1, 0);
        if (qa.size() != 0) void'(qa.pop_front());
        if (qb.size() != 0) void'(qb.pop_front());
    endtask
    initial begin
        int pulses;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", a.valid_o, 0);
        check("rst_delay", a.delay_o, 0);
        check("rst_count", a.count_o, 0);
        check("rst_ovf", a.overflow_o, 0);
        check("rst_pto", a.p_timeout_o, 0);
        rst = 0;
        step(0, 0, 0, 0, 0);
        measure(37);
        check("basic_delay", a.delay_o, 37);
        check("basic_flag", a.timeout_flag_o, 0);
        check("basic_valid", a.valid_o, 1);
        check("basic_count", a.count_o, 1);
        pop_check("basic_pop");
        check("basic_empty_valid", a.valid_o, 0);
        check("basic_empty_delay", a.delay_o, 0);
        measure(1200);
        check("sat_delay", a.delay_o, 999);
        pop_check("sat_pop");
        limit = 16'd50;
        pulses = 0;
        step(1, 0, 0, 0, 0);
        repeat (60) begin
            step(0, 0, 1, 0, 0);
            if (a.p_timeout_o) pulses++;
        end
        exp_push({1'b1, 16'd50});
        check("to_pulses", pulses, 1);
        check("to_count", a.count_o, 1);
        step(0, 1, 0, 0, 0);
        check("to_late_rx_count", a.count_o, 1);
        pop_check("to_pop");
        limit = '0;
        for (int i = 1; i <= 6; i++) measure(i);
        check("ovf_a_count", a.count_o, 4);
        check("ovf_b_count", b.count_o, 4);
        check("ovf_a_flag", a.overflow_o, 1);
        check("ovf_b_flag", b.overflow_o, 1);
        repeat (4) pop_check("ovf_pop");
        for (int i = 7; i <= 9; i++) measure(i);
        check("clr_pre_count", a.count_o, 3);
        step(0, 0, 0, 0, 1);
        qa.delete();
        qb.delete();
        check("clr_count", a.count_o, 0);
        check("clr_ovf", a.overflow_o, 0);
        check("clr_valid", a.valid_o, 0);
        for (int i = 10; i <= 13; i++) measure(i);
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0);
        void'(qa.pop_front());
        void'(qb.pop_front());
        exp_push({1'b0, 16'd5});
        check("pp_a_count", a.count_o, 4);
        check("pp_b_count", b.count_o, 4);
        check("pp_a_ovf", a.overflow_o, 0);
        check("pp_b_ovf", b.overflow_o, 0);
        repeat (4) pop_check("pp_pop");
        step(1, 0, 0, 0, 0);
        repeat (12) step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        exp_push({1'b0, 16'd12});
        repeat (3) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        exp_push({1'b0, 16'd3});
        check("sim_count", a.count_o, 2);
        repeat (2) pop_check("sim_pop");
        measure(4);
        step(1, 0, 0, 0, 0);
        repeat (10) step(0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        qa.delete();
        qb.delete();
        check("mid_rst_valid", a.valid_o, 0);
        check("mid_rst_count", a.count_o, 0);
        check("mid_rst_delay", a.delay_o, 0);
        @(posedge clk);
        #1;
        rst = 0;
        step(0, 1, 0, 0, 0);
        check("post_rst_count", a.count_o, 0);
        check("post_rst_valid", a.valid_o, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ans_delay_measure_fifo.md
Name: ans_delay_measure_fifo

Overview:
Parametrised successor to the UART answer-delay meter. It measures the interval from the tx core's "send finished" strobe to the rx core's "data received" strobe, in time-base ticks. Each result goes into a configurable-depth, show-ahead result FIFO, with a timeout flag and overflow tracking. It sits between the tx/rx cores and the register interface, which pops results one at a time.

Parameters:
CNT_W, 16, width of the delay counter and of the stored delay value
DEPTH, 4, result FIFO depth; power of 2, at least 2
MAX_DLY, 999, saturation value of the delay counter; must be below 2**CNT_W
OVERWRITE, 1, 1 = a push when full drops the oldest entry; 0 = a push when full drops the new entry

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  reset, asynchronous and active-high
p_send_finished_i  in  1  one-cycle strobe from tx core: last stop bit sent
p_data_received_i  in  1  one-cycle strobe from rx core: first response byte detected
p_tick_i  in  1  one-cycle time-base strobe (e.g. 10 MHz enable)
p_rd_i  in  1  one-cycle pop strobe from register interface
p_clr_i  in  1  synchronous clear of the whole block
timeout_limit_i  in  CNT_W  timeout threshold in ticks; 0 disables timeout
delay_o  out  CNT_W  delay field of the FIFO head entry; 0 when empty
timeout_flag_o  out  1  timeout bit of the FIFO head entry; 0 when empty
valid_o  out  1  FIFO non-empty
count_o  out  $clog2(DEPTH)+1  number of stored entries
p_timeout_o  out  1  one-cycle pulse when a timeout entry is pushed
overflow_o  out  1  sticky: an entry was lost to a full FIFO

Behaviour:
- Reset (rst=1, asynchronous): FSM=IDLE; counter=0; FIFO empty; all outputs 0.
- FSM states:
  - IDLE: send_finished -> WAIT with cnt=0.
  - WAIT: data_received -> push {0,cnt} and go to IDLE. Timeout condition -> push {1,cnt}, pulse p_timeout_o, go to TIMEDOUT.
  - TIMEDOUT: data_received -> IDLE, no push. send_finished -> WAIT with cnt=0.
- Timeout condition: state is WAIT, timeout_limit_i != 0, cnt >= timeout_limit_i, and no data_received in the same cycle. Received has priority over timeout.
- Counter:
  - Increments on p_tick_i only in WAIT.
  - Saturates: holds at MAX_DLY once reached, never wraps.
  - The value captured on a push is the pre-increment register value, even if a tick arrives in the same cycle.
- send_finished and data_received in the same cycle:
  - In WAIT: push {0,cnt}, then restart WAIT with cnt=0.
  - In IDLE or TIMEDOUT: go to WAIT with cnt=0, no push.
- data_received while in IDLE: ignored.
- FIFO is show-ahead. A push at cycle N is visible on delay_o/valid_o/count_o at N+1.
- Pop:
  - p_rd_i with valid_o=1 removes the head; the next entry (or 0) appears at N+1.
  - Pop on empty is ignored.
- Push and pop in the same cycle:
  - Non-empty: both happen; count is unchanged; no overflow.
  - Empty: push only.
- Push when full with no pop:
  - OVERWRITE=1: oldest entry dropped, new entry stored.
  - OVERWRITE=0: new entry dropped.
  - Either case: overflow_o set; count stays DEPTH.
- p_clr_i has the highest synchronous priority: flush FIFO, overflow_o=0, cnt=0, FSM=IDLE. All other inputs in that cycle are ignored.
- Pointers wrap modulo DEPTH. count_o is tracked separately, so full (count_o=DEPTH) and empty are unambiguous.
- Reset asserted mid-interval: all state is discarded immediately; no partial push.

Decomposition:
- Package ans_delay_pkg:
  - FSM state enum (IDLE, WAIT, TIMEDOUT)
  - entry struct {timeout bit, delay[CNT_W-1:0]}
  - clog2-based width helper constants
- One sub-module, ans_delay_fifo: a parametrised circular buffer with show-ahead output, count, and OVERWRITE mode. The top module holds the FSM, counter and timeout logic.

Test Plan:
- Basic measurement: send_finished, then 37 ticks, then data_received -> next cycle delay_o=37, timeout_flag_o=0, valid_o=1, count_o=1; pop -> valid_o=0, delay_o=0.
- Saturation: MAX_DLY=999, timeout disabled, 1200 ticks, then data_received -> delay_o=999.
- Timeout: timeout_limit_i=50, no response -> p_timeout_o pulses once; entry {1,50} pushed. A later data_received produces no push; count_o=1.
- Overflow with OVERWRITE=1, DEPTH=4: six transactions with delays 1..6 -> count_o=4, overflow_o=1, pops yield 3,4,5,6. The same test with OVERWRITE=0 yields 1,2,3,4.
- Simultaneous events:
  - push and pop in one cycle when full -> count stays 4, overflow_o stays 0;
  - send_finished and data_received together in WAIT with cnt=12 -> entry 12 pushed and a new interval starts at 0.
- Clear and reset: p_clr_i with 3 entries and overflow set -> next cycle count_o=0, overflow_o=0. Asserting rst mid-WAIT -> outputs 0 immediately; the next data_received pushes nothing.
